// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver with a first-word fall-through byte FIFO and sticky error flags.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_resetn,
    input  logic                          rx,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          parity_err,
    output logic [2:0]                    state_dbg
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int CW   = (CPB > 2) ? $clog2(CPB) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   BIT_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(CPB / 2 - 1);
    localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3,
        S_WAIT_IDLE = 3'd4, S_PARITY = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3,
        S_WAIT_IDLE = 3'd4
    } state_t;
`endif

    state_t          state, state_nxt;
    logic            rx_meta, rxs;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      bit_idx, bit_idx_nxt;
    logic [7:0]      shift, shift_nxt;
    logic            push, frame_set, parity_set, byte_ok;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad, par_bad_nxt;
    assign byte_ok = !par_bad;
`else
    assign byte_ok = 1'b1;
`endif

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shift   <= shift_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        push        = 1'b0;
        frame_set   = 1'b0;
        parity_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
`endif
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_nxt = S_START;
                    cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            // Counting a full bit from mid-start lands every sample mid-bit.
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt            = '0;
                    shift_nxt[bit_idx] = rxs;
                    bit_idx_nxt        = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    par_bad_nxt = (^shift) ^ rxs;
                    parity_set  = (^shift) ^ rxs;
                    state_nxt   = S_STOP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rxs) begin
                        push      = byte_ok;
                        state_nxt = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rxs) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign state_dbg = state;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
    logic [CNTW-1:0] count, count_nxt;
    logic            do_pop, do_push, overrun_set;

    assign do_pop      = rd_en && (count != '0);
    assign do_push     = push && ((count != FULL_CNT) || do_pop);
    assign overrun_set = push && (count == FULL_CNT) && !do_pop;
    assign rd_ptr_nxt  = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)      count_nxt = count + 1'b1;
        else if (do_pop && !do_push) count_nxt = count - 1'b1;
    end

    always_ff @(posedge sys_clk) begin
        if (do_push) mem[wr_ptr] <= shift;
    end

    // rd_data is registered so it resets to 0 and holds when the FIFO drains.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= 8'h00;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr_nxt;
            count  <= count_nxt;
            if (count_nxt != '0)
                rd_data <= (do_push && (wr_ptr == rd_ptr_nxt)) ? shift : mem[rd_ptr_nxt];
        end
    end

    assign rx_valid   = (count != '0);
    assign fifo_count = count;

    // A new error event in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_set   | (frame_err   & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) parity_err <= 1'b0;
        else             parity_err <= parity_set | (parity_err & ~err_clr);
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks per bit; expected bytes go through exp_q.
module tb_uart_rx_fifo;

    localparam int CLK_FREQ = 160;
    localparam int BAUD     = 10;
    localparam int CPB      = 16;
    localparam int DEPTH    = 16;
`ifdef UART_RX_PARITY_EN
    localparam int RISE_LAT = 171;
`else
    localparam int RISE_LAT = 155;
`endif

    logic       sys_clk, sys_resetn, rx, rd_en, err_clr;
    logic [7:0] rd_data;
    logic       rx_valid, frame_err, overrun_err, parity_err;
    logic [4:0] fifo_count;
    logic [2:0] state_dbg;

    uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .sys_clk(sys_clk), .sys_resetn(sys_resetn), .rx(rx), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data), .rx_valid(rx_valid),
        .fifo_count(fifo_count), .frame_err(frame_err), .overrun_err(overrun_err),
        .parity_err(parity_err), .state_dbg(state_dbg)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rise_cyc = 0;
    logic prev_valid = 1'b0;
    logic [7:0] exp_q[$];
    logic par_flip = 1'b0;

    always @(posedge sys_clk) cyc++;
    always @(negedge sys_clk) begin
        if (rx_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = rx_valid;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ par_flip;
        tick(CPB);
`endif
        rx = stop_val;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
        exp_q.push_back(b);
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] e;
        e = exp_q.pop_front();
        chk(tag, {24'h0, rd_data}, {24'h0, e});
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
    endtask

    initial begin
        string hello;
        int start_cyc;
        hello = "Hello, World!   ";
        rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0; sys_resetn = 1'b0;
        tick(3);
        sys_resetn = 1'b1;
        tick(2);
        chk("reset_rd_data", {24'h0, rd_data}, 32'h0);
        chk("reset_valid", {31'h0, rx_valid}, 32'h0);
        chk("reset_count", {27'h0, fifo_count}, 32'h0);
        chk("reset_errs", {29'h0, frame_err, overrun_err, parity_err}, 32'h0);
        chk("reset_state", {29'h0, state_dbg}, 32'h0);

        // single byte and rx_valid latency from the start edge
        start_cyc = cyc;
        send_byte(8'h48);
        chk("t1_latency", rise_cyc - start_cyc, RISE_LAT);
        chk("t1_rd_data", {24'h0, rd_data}, 32'h48);
        chk("t1_count", {27'h0, fifo_count}, 32'd1);
        chk("t1_errs", {29'h0, frame_err, overrun_err, parity_err}, 32'h0);
        pop_check("t1_pop");
        chk("t1_valid_after_pop", {31'h0, rx_valid}, 32'h0);

        // fill exactly to depth, then drain in order
        for (int i = 0; i < 16; i++) send_byte(hello[i]);
        chk("t2_count_full", {27'h0, fifo_count}, 32'd16);
        chk("t2_no_overrun", {31'h0, overrun_err}, 32'h0);
        for (int i = 0; i < 16; i++) pop_check("t2_pop");
        chk("t2_valid_empty", {31'h0, rx_valid}, 32'h0);
        chk("t2_count_empty", {27'h0, fifo_count}, 32'd0);

        // overflow by one byte
        for (int i = 0; i < 17; i++) begin
            send_frame(8'(i), 1'b1);
            if (i < 16) exp_q.push_back(8'(i));
        end
        chk("t3_count", {27'h0, fifo_count}, 32'd16);
        chk("t3_overrun", {31'h0, overrun_err}, 32'h1);
        chk("t3_frame", {31'h0, frame_err}, 32'h0);
        for (int i = 0; i < 16; i++) pop_check("t3_pop");
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("t3_overrun_clr", {31'h0, overrun_err}, 32'h0);

        // glitch shorter than half a bit
        rx = 1'b0; tick(4); rx = 1'b1; tick(30);
        chk("t4_state_idle", {29'h0, state_dbg}, 32'h0);
        chk("t4_count", {27'h0, fifo_count}, 32'd0);
        chk("t4_errs", {29'h0, frame_err, overrun_err, parity_err}, 32'h0);

        // broken stop bit, then recovery
        send_frame(8'h55, 1'b0);
        tick(CPB);
        chk("t5_wait_idle", {29'h0, state_dbg}, 32'd4);
        chk("t5_frame_err", {31'h0, frame_err}, 32'h1);
        chk("t5_count", {27'h0, fifo_count}, 32'd0);
        rx = 1'b1; tick(8);
        chk("t5_back_idle", {29'h0, state_dbg}, 32'h0);
        send_byte(8'hA5);
        chk("t5_count_a5", {27'h0, fifo_count}, 32'd1);
        pop_check("t5_pop_a5");
        chk("t5_frame_sticky", {31'h0, frame_err}, 32'h1);
        err_clr = 1'b1; tick(1); err_clr = 1'b0;
        chk("t5_frame_clr", {31'h0, frame_err}, 32'h0);

        // reset mid-frame with bytes buffered
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        chk("t6_count3", {27'h0, fifo_count}, 32'd3);
        rx = 1'b0; tick(CPB);
        rx = 1'b1; tick(2 * CPB);
        chk("t6_in_data", {29'h0, state_dbg}, 32'd2);
        sys_resetn = 1'b0; tick(2);
        chk("t6_count_rst", {27'h0, fifo_count}, 32'd0);
        chk("t6_valid_rst", {31'h0, rx_valid}, 32'h0);
        chk("t6_rd_data_rst", {24'h0, rd_data}, 32'h0);
        sys_resetn = 1'b1;
        exp_q.delete();
        tick(12 * CPB);
        send_byte(8'h3C);
        chk("t6_count_3c", {27'h0, fifo_count}, 32'd1);
        pop_check("t6_pop_3c");

`ifdef UART_RX_PARITY_EN
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        chk("t7_parity_err", {31'h0, parity_err}, 32'h1);
        chk("t7_discarded", {27'h0, fifo_count}, 32'd0);
        par_flip = 1'b0;
        send_byte(8'h07);
        chk("t7_accepted", {27'h0, fifo_count}, 32'd1);
        pop_check("t7_pop_07");
`else
        chk("t7_parity_tied", {31'h0, parity_err}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
